id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register of the 16-bit pipelined core, directly downstream of the opcode decoder.
//  Latches decoded control, operands and register numbers into EX each cycle.
//  Detects load-use hazards and raises a stall. Inserts bubbles on stall and on branch flush.
//  Latches a sticky halt once an HLT instruction reaches EX.
// PARAMETERS
//  DATA_W      16  operand / immediate / PC width
//  REG_ADDR_W  4   register number width (R0 reads as zero)
//  OPC_W       4   opcode width
// PORTS
//  clk          in   1           core clock; all state updates on rising edge
//  rst          in   1           synchronous, active-high reset
//  id_valid     in   1           ID holds a real instruction
//  id_opCode    in   OPC_W       opcode of ID instruction
//  id_ctrl      in   8           {memRead,memWrite,memToReg,ALUsrc,regWrite,branch,writeFlag,regWriteSelect} from decoder
//  id_rs,id_rt  in   REG_ADDR_W  source register numbers
//  id_rd        in   REG_ADDR_W  destination register number
//  id_uses_rs   in   1           ID instruction reads rs
//  id_uses_rt   in   1           ID instruction reads rt
//  id_srcA      in   DATA_W      register-file read data A
//  id_srcB      in   DATA_W      register-file read data B
//  id_imm       in   DATA_W      sign-extended immediate
//  id_pcNext    in   DATA_W      PC+2 of ID instruction
//  flush        in   1           taken branch resolved downstream; squash ID instruction
//  ex_valid     out  1           EX holds a real instruction
//  ex_opCode    out  OPC_W       registered opcode
//  ex_ctrl      out  8           registered control, same bit order as id_ctrl
//  ex_rs,ex_rt,ex_rd  out REG_ADDR_W  registered register numbers
//  ex_srcA,ex_srcB,ex_imm,ex_pcNext  out DATA_W  registered data
//  stall        out  1           hold PC and IF/ID this cycle (combinational)
//  halted       out  1           sticky: HLT has reached EX
// BEHAVIOUR
//  Reset: all ex_* outputs = 0, halted = 0; stall therefore 0.
//  Hazard (combinational, same cycle):
//    lu = ex_valid & ex_ctrl[7] & (ex_rd != 0) & id_valid &
//         ((id_uses_rs & id_rs == ex_rd) | (id_uses_rt & id_rt == ex_rd))
//    stall = halted | (lu & ~flush)
//  Per rising edge, priority highest first:
//    1 rst      -> reset values above
//    2 flush    -> bubble: ex_valid=0, ex_ctrl=0, ex_opCode=0
//    3 halted   -> bubble
//    4 lu       -> bubble; ID instruction held upstream, enters EX next edge
//    5 else     -> ex_* <= id_*; ex_valid <= id_valid; ex_ctrl <= id_valid ? id_ctrl : 0
//  Bubble leaves ex_rs/rt/rd/srcA/srcB/imm/pcNext unchanged; only valid, opcode, ctrl zeroed.
//  Latency: 1 cycle ID->EX. Load-use costs exactly 1 bubble; bubble clears ex_ctrl[7], so stall drops next cycle.
//  Halt: halted <= 1 at the edge after ex_valid & ex_opCode==4'hF & ~flush. Held until rst; all later ID inputs ignored.
//  flush together with lu: flush wins, stall = 0, bubble inserted.
//  rst mid-stall or while halted: rst wins; next cycle normal operation.
// TESTING
//  T1 rst=1 for 2 cycles with id_valid=1, id_ctrl=8'h1B -> all ex_* = 0, stall=0, halted=0.
//  T2 ADD: id_ctrl=8'h1B, id_srcA=16'h1234, id_rd=5 -> next edge ex_valid=1, ex_ctrl=8'h1B, ex_srcA=16'h1234, ex_rd=5.
//  T3 LW (8'hA9, rd=3) in EX; ID uses_rs=1, rs=3 -> stall=1 that cycle; next cycle ex_valid=0, ex_ctrl=0, stall=0; following edge dependent enters EX.
//  T4 LW rd=0 with rs=0, or uses_rt=0 with rt=3 matching -> stall=0, no bubble.
//  T5 flush=1 while lu=1 -> stall=0; next edge ex_valid=0, ex_ctrl=0.
//  T6 HLT (opCode 4'hF) enters EX -> halted=1 next edge, stall=1; later ADDs never reach EX; rst clears halted.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID/EX stage bundle: decoded ID inputs, registered EX outputs, hazard status
interface id_ex_stage_if #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int OPC_W      = 4
);
    logic                  id_valid;
    logic [OPC_W-1:0]      id_opCode;
    logic [7:0]            id_ctrl;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic [DATA_W-1:0]     id_srcA;
    logic [DATA_W-1:0]     id_srcB;
    logic [DATA_W-1:0]     id_imm;
    logic [DATA_W-1:0]     id_pcNext;
    logic                  flush;

    logic                  ex_valid;
    logic [OPC_W-1:0]      ex_opCode;
    logic [7:0]            ex_ctrl;
    logic [REG_ADDR_W-1:0] ex_rs;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [DATA_W-1:0]     ex_srcA;
    logic [DATA_W-1:0]     ex_srcB;
    logic [DATA_W-1:0]     ex_imm;
    logic [DATA_W-1:0]     ex_pcNext;
    logic                  stall;
    logic                  halted;

    modport master (
        output id_valid, id_opCode, id_ctrl, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
               id_srcA, id_srcB, id_imm, id_pcNext, flush,
        input  ex_valid, ex_opCode, ex_ctrl, ex_rs, ex_rt, ex_rd,
               ex_srcA, ex_srcB, ex_imm, ex_pcNext, stall, halted
    );

    modport slave (
        input  id_valid, id_opCode, id_ctrl, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
               id_srcA, id_srcB, id_imm, id_pcNext, flush,
        output ex_valid, ex_opCode, ex_ctrl, ex_rs, ex_rt, ex_rd,
               ex_srcA, ex_srcB, ex_imm, ex_pcNext, stall, halted
    );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall, flush bubbles and sticky halt
module id_ex_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int OPC_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    id_ex_stage_if.slave     bus
);
    localparam logic [OPC_W-1:0] OPC_HLT = '1;

    logic                  valid_q;
    logic [OPC_W-1:0]      opc_q;
    logic [7:0]            ctrl_q;
    logic [REG_ADDR_W-1:0] rs_q, rt_q, rd_q;
    logic [DATA_W-1:0]     src_a_q, src_b_q, imm_q, pc_next_q;
    logic                  halted_q;
    logic                  lu;

    // Load in EX whose destination is read by the instruction waiting in ID.
    always_comb begin
        lu = valid_q && ctrl_q[7] && (rd_q != '0) && bus.id_valid &&
             ((bus.id_uses_rs && (bus.id_rs == rd_q)) ||
              (bus.id_uses_rt && (bus.id_rt == rd_q)));
    end

    assign bus.stall     = halted_q | (lu & ~bus.flush);
    assign bus.halted    = halted_q;
    assign bus.ex_valid  = valid_q;
    assign bus.ex_opCode = opc_q;
    assign bus.ex_ctrl   = ctrl_q;
    assign bus.ex_rs     = rs_q;
    assign bus.ex_rt     = rt_q;
    assign bus.ex_rd     = rd_q;
    assign bus.ex_srcA   = src_a_q;
    assign bus.ex_srcB   = src_b_q;
    assign bus.ex_imm    = imm_q;
    assign bus.ex_pcNext = pc_next_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            opc_q     <= '0;
            ctrl_q    <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            src_a_q   <= '0;
            src_b_q   <= '0;
            imm_q     <= '0;
            pc_next_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            if (valid_q && (opc_q == OPC_HLT) && !bus.flush) begin
                halted_q <= 1'b1;
            end
            // Bubbles zero only valid/opcode/ctrl; the datapath fields keep their old values.
            if (bus.flush || halted_q || lu) begin
                valid_q <= 1'b0;
                opc_q   <= '0;
                ctrl_q  <= '0;
            end else begin
                valid_q   <= bus.id_valid;
                opc_q     <= bus.id_opCode;
                ctrl_q    <= bus.id_valid ? bus.id_ctrl : 8'h00;
                rs_q      <= bus.id_rs;
                rt_q      <= bus.id_rt;
                rd_q      <= bus.id_rd;
                src_a_q   <= bus.id_srcA;
                src_b_q   <= bus.id_srcB;
                imm_q     <= bus.id_imm;
                pc_next_q <= bus.id_pcNext;
            end
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    id_ex_stage_if #(.DATA_W(16), .REG_ADDR_W(4), .OPC_W(4)) bus ();

    id_ex_stage #(.DATA_W(16), .REG_ADDR_W(4), .OPC_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] opc, input logic [7:0] ctrl,
                         input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                         input logic urs, input logic urt, input logic [15:0] a);
        bus.id_valid   = v;
        bus.id_opCode  = opc;
        bus.id_ctrl    = ctrl;
        bus.id_rs      = rs;
        bus.id_rt      = rt;
        bus.id_rd      = rd;
        bus.id_uses_rs = urs;
        bus.id_uses_rt = urt;
        bus.id_srcA    = a;
        bus.id_srcB    = a ^ 16'hFFFF;
        bus.id_imm     = 16'h0004;
        bus.id_pcNext  = 16'h0100;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.flush = 1'b0;
        rst = 1'b1;

        // T1 reset with a live instruction presented
        drive(1'b1, 4'h1, 8'h1B, 4'd1, 4'd2, 4'd5, 1'b1, 1'b1, 16'h1234);
        tick();
        tick();
        check("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("rst_ex_ctrl", {24'd0, bus.ex_ctrl}, 32'd0);
        check("rst_ex_srcA", {16'd0, bus.ex_srcA}, 32'd0);
        check("rst_ex_rd", {28'd0, bus.ex_rd}, 32'd0);
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_halted", {31'd0, bus.halted}, 32'd0);

        // T2 ADD passes through in one cycle
        rst = 1'b0;
        tick();
        check("add_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
        check("add_ex_ctrl", {24'd0, bus.ex_ctrl}, 32'h1B);
        check("add_ex_srcA", {16'd0, bus.ex_srcA}, 32'h1234);
        check("add_ex_rd", {28'd0, bus.ex_rd}, 32'd5);
        check("add_ex_opCode", {28'd0, bus.ex_opCode}, 32'd1);

        // T3 load-use: one bubble, then dependent enters
        drive(1'b1, 4'h8, 8'hA9, 4'd1, 4'd0, 4'd3, 1'b1, 1'b0, 16'h0040);
        tick();
        drive(1'b1, 4'h1, 8'h1B, 4'd3, 4'd0, 4'd6, 1'b1, 1'b0, 16'h1111);
        #1;
        check("lu_stall", {31'd0, bus.stall}, 32'd1);
        tick();
        check("lu_bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("lu_bubble_ctrl", {24'd0, bus.ex_ctrl}, 32'd0);
        check("lu_bubble_rd_kept", {28'd0, bus.ex_rd}, 32'd3);
        check("lu_stall_drop", {31'd0, bus.stall}, 32'd0);
        tick();
        check("lu_dep_valid", {31'd0, bus.ex_valid}, 32'd1);
        check("lu_dep_rd", {28'd0, bus.ex_rd}, 32'd6);
        check("lu_dep_srcA", {16'd0, bus.ex_srcA}, 32'h1111);

        // T4a load to R0 never stalls
        drive(1'b1, 4'h8, 8'hA9, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0, 16'h0040);
        tick();
        drive(1'b1, 4'h1, 8'h1B, 4'd0, 4'd2, 4'd7, 1'b1, 1'b1, 16'h2222);
        #1;
        check("r0_stall", {31'd0, bus.stall}, 32'd0);
        tick();
        check("r0_no_bubble", {28'd0, bus.ex_rd}, 32'd7);

        // T4b matching rt that is not read does not stall
        drive(1'b1, 4'h8, 8'hA9, 4'd1, 4'd0, 4'd3, 1'b1, 1'b0, 16'h0040);
        tick();
        drive(1'b1, 4'h1, 8'h1B, 4'd1, 4'd3, 4'd8, 1'b1, 1'b0, 16'h3333);
        #1;
        check("rt_unused_stall", {31'd0, bus.stall}, 32'd0);
        tick();
        check("rt_unused_valid", {31'd0, bus.ex_valid}, 32'd1);
        check("rt_unused_rd", {28'd0, bus.ex_rd}, 32'd8);

        // T5 flush overrides load-use
        drive(1'b1, 4'h8, 8'hA9, 4'd1, 4'd0, 4'd3, 1'b1, 1'b0, 16'h0040);
        tick();
        drive(1'b1, 4'h1, 8'h1B, 4'd3, 4'd0, 4'd9, 1'b1, 1'b0, 16'h4444);
        bus.flush = 1'b1;
        #1;
        check("flush_lu_stall", {31'd0, bus.stall}, 32'd0);
        tick();
        bus.flush = 1'b0;
        check("flush_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("flush_ctrl", {24'd0, bus.ex_ctrl}, 32'd0);

        // T6 halt is sticky until reset
        drive(1'b1, 4'hF, 8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0000);
        tick();
        check("hlt_in_ex", {28'd0, bus.ex_opCode}, 32'hF);
        check("hlt_not_yet", {31'd0, bus.halted}, 32'd0);
        drive(1'b0, 4'h1, 8'h1B, 4'd1, 4'd2, 4'd5, 1'b1, 1'b1, 16'h5555);
        tick();
        check("halted_set", {31'd0, bus.halted}, 32'd1);
        check("halted_stall", {31'd0, bus.stall}, 32'd1);
        check("idle_ctrl_zero", {24'd0, bus.ex_ctrl}, 32'd0);
        drive(1'b1, 4'h1, 8'h1B, 4'd1, 4'd2, 4'd5, 1'b1, 1'b1, 16'h5555);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halted_blocks", {31'd0, bus.ex_valid}, 32'd0);
        end
        rst = 1'b1;
        tick();
        check("rst_clr_halted", {31'd0, bus.halted}, 32'd0);
        check("rst_clr_stall", {31'd0, bus.stall}, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_valid", {31'd0, bus.ex_valid}, 32'd1);
        check("post_rst_srcA", {16'd0, bus.ex_srcA}, 32'h5555);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
